// File: rtl/sqrt_pkg.sv
// Shared sizing helpers for the pipelined square root.
package sqrt_pkg;

    // Extra sign bit on top of the remainder width for the restoring trial subtraction.
    localparam int unsigned REM_GUARD = 1;

    // Result width: integer bits cover ceil(in_w/2), plus the requested fraction bits.
    function automatic int unsigned sqrt_out_w(input int unsigned in_w,
                                               input int unsigned out_f);
        return (in_w + 1) / 2 + out_f;
    endfunction

    // Number of register stages needed to resolve out_w bits at bits_per_cyc per stage.
    function automatic int unsigned sqrt_lat(input int unsigned out_w,
                                             input int unsigned bits_per_cyc);
        return (out_w + bits_per_cyc - 1) / bits_per_cyc;
    endfunction

endpackage

// File: rtl/sqrt_pipe_stage.sv
// One register stage of the restoring square root: resolves NBITS result bits MSB-first,
// starting at result step FIRST_BIT, then registers the partial state when en is high.
module sqrt_pipe_stage
    import sqrt_pkg::*;
#(
    parameter int unsigned OUT_W     = 13,
    parameter int unsigned NBITS     = 1,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned FIRST_BIT = 0,
    localparam int unsigned REM_W    = OUT_W + 1,
    localparam int unsigned TW       = REM_W + REM_GUARD,
    localparam int unsigned RAD_W    = 2 * OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [RAD_W-1:0] in_rad,
    input  logic [REM_W-1:0] in_rem,
    input  logic [OUT_W-1:0] in_root,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [RAD_W-1:0] out_rad,
    output logic [REM_W-1:0] out_rem,
    output logic [OUT_W-1:0] out_root,
    output logic [TAG_W-1:0] out_tag
);

    logic             valid_d, valid_q;
    logic [RAD_W-1:0] rad_d, rad_q;
    logic [REM_W-1:0] rem_d, rem_q;
    logic [OUT_W-1:0] root_d, root_q;
    logic [TAG_W-1:0] tag_d, tag_q;

    logic signed [TW-1:0] trial;
    logic [REM_W-1:0]     rem_c;
    logic [OUT_W-1:0]     root_c;
    logic [1:0]           pair;
    int unsigned          lsb;

    // Chained restoring steps. Truncating arithmetic is exact: the true trial always fits
    // in TW signed bits, and every kept/restored remainder fits in REM_W bits.
    always_comb begin
        trial  = '0;
        pair   = '0;
        lsb    = 0;
        rem_c  = in_rem;
        root_c = in_root;
        for (int unsigned i = 0; i < NBITS; i++) begin
            lsb   = RAD_W - 2 - 2 * (FIRST_BIT + i);
            pair  = in_rad[lsb +: 2];
            trial = TW'({rem_c, pair}) - TW'({root_c, 2'b01});
            if (trial[TW-1]) begin
                rem_c = REM_W'({rem_c, pair});
            end else begin
                rem_c = trial[REM_W-1:0];
            end
            root_c = OUT_W'({root_c, ~trial[TW-1]});
        end
    end

    // Next state: advance on enable, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        tag_d   = tag_q;
        if (en) begin
            valid_d = in_valid;
            rad_d   = in_rad;
            rem_d   = rem_c;
            root_d  = root_c;
            tag_d   = in_tag;
        end
    end

    // Stage registers; data is cleared too so the final stage presents zeros after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q;
    assign out_rad   = rad_q;
    assign out_rem   = rem_q;
    assign out_root  = root_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/sqrt_pipe.sv
// Fully pipelined restoring square root with valid/ready flow control, tag and remainder.
// out_root = floor(sqrt(in_data * 4^OUT_F)), out_rem = in_data * 4^OUT_F - out_root^2.
module sqrt_pipe
    import sqrt_pkg::*;
#(
    parameter int unsigned IN_W         = 18,
    parameter int unsigned OUT_F        = 4,
    parameter int unsigned BITS_PER_CYC = 1,
    parameter int unsigned TAG_W        = 8,
    localparam int unsigned OUT_I       = (IN_W + 1) / 2,
    localparam int unsigned OUT_W       = sqrt_out_w(IN_W, OUT_F),
    localparam int unsigned REM_W       = OUT_W + 1,
    localparam int unsigned LAT         = sqrt_lat(OUT_W, BITS_PER_CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_root,
    output logic [REM_W-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned RAD_W = 2 * OUT_W;

    logic             en;
    logic [LAT:0]     vld_s;
    logic [RAD_W-1:0] rad_s  [LAT+1];
    logic [REM_W-1:0] rem_s  [LAT+1];
    logic [OUT_W-1:0] root_s [LAT+1];
    logic [TAG_W-1:0] tag_s  [LAT+1];
    logic [2*OUT_I-1:0] rad_ext;
    logic             unused_rad;

    // Zero-extend to an even number of integer bits first so odd IN_W needs no scaling fix.
    assign rad_ext = (2 * OUT_I)'(in_data);

    // Single global enable: the whole pipe moves unless the output is stalled.
    assign en       = !vld_s[LAT] || out_ready;
    assign in_ready = en;

    assign vld_s[0]  = in_valid;
    assign rad_s[0]  = RAD_W'(rad_ext) << (2 * OUT_F);
    assign rem_s[0]  = '0;
    assign root_s[0] = '0;
    assign tag_s[0]  = in_tag;

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        // The last stage picks up whatever bits remain when BITS_PER_CYC does not divide OUT_W.
        localparam int unsigned NB = (k == LAT - 1) ?
                                     OUT_W - (LAT - 1) * BITS_PER_CYC : BITS_PER_CYC;
        sqrt_pipe_stage #(
            .OUT_W    (OUT_W),
            .NBITS    (NB),
            .TAG_W    (TAG_W),
            .FIRST_BIT(k * BITS_PER_CYC)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_valid (vld_s[k]),
            .in_rad   (rad_s[k]),
            .in_rem   (rem_s[k]),
            .in_root  (root_s[k]),
            .in_tag   (tag_s[k]),
            .out_valid(vld_s[k+1]),
            .out_rad  (rad_s[k+1]),
            .out_rem  (rem_s[k+1]),
            .out_root (root_s[k+1]),
            .out_tag  (tag_s[k+1])
        );
    end

    // The radicand is fully consumed by the last stage.
    assign unused_rad = ^rad_s[LAT];

    assign out_valid = vld_s[LAT];
    assign out_root  = root_s[LAT];
    assign out_rem   = rem_s[LAT];
    assign out_tag   = tag_s[LAT];

endmodule

// File: tb/tb_sqrt_pipe.sv
// Self-checking bench for sqrt_pipe: random traffic against an arithmetic reference model.
module tb_sqrt_pipe;

    localparam int LA = 13;  // default config latency
    localparam int LB = 4;   // BITS_PER_CYC=4
    localparam int LC = 9;   // IN_W=17, OUT_F=0

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: defaults
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
    logic [17:0] a_in_data = '0;
    logic [7:0]  a_in_tag = '0, a_out_tag;
    logic [12:0] a_out_root;
    logic [13:0] a_out_rem;

    // DUT B: 4 bits per stage
    logic        b_in_valid = 0, b_in_ready, b_out_valid;
    logic        b_out_ready = 1;
    logic [17:0] b_in_data = '0;
    logic [7:0]  b_in_tag = '0, b_out_tag;
    logic [12:0] b_out_root;
    logic [13:0] b_out_rem;

    // DUT C: odd width, no fraction
    logic        c_in_valid = 0, c_in_ready, c_out_valid;
    logic        c_out_ready = 1;
    logic [16:0] c_in_data = '0;
    logic [7:0]  c_in_tag = '0, c_out_tag;
    logic [8:0]  c_out_root;
    logic [9:0]  c_out_rem;

    sqrt_pipe u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_tag(a_in_tag), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_root(a_out_root), .out_rem(a_out_rem),
        .out_tag(a_out_tag)
    );

    sqrt_pipe #(.BITS_PER_CYC(4)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_tag(b_in_tag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_root(b_out_root), .out_rem(b_out_rem),
        .out_tag(b_out_tag)
    );

    sqrt_pipe #(.IN_W(17), .OUT_F(0)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_tag(c_in_tag), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_root(c_out_root), .out_rem(c_out_rem),
        .out_tag(c_out_tag)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    // Reference occupancy of DUT A: slot LA-1 is what the output must show.
    bit          m_v [LA];
    logic [17:0] m_d [LA];
    logic [7:0]  m_t [LA];

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Integer square root by greedy bit setting with true multiplication.
    task automatic ref_sqrt(input longint v, output longint r, output longint m);
        longint t;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'sd1 <<< b);
            if (t * t <= v) r = t;
        end
        m = v - r * r;
    endtask

    // One cycle on DUT A: drive, check outputs against the model, advance the model.
    task automatic step_a(input logic rst_v, input logic iv, input logic [17:0] d,
                          input logic [7:0] t, input logic ordy);
        longint r, m;
        bit en_m;
        @(negedge clk);
        rst = rst_v;
        a_in_valid = iv;
        a_in_data = d;
        a_in_tag = t;
        a_out_ready = ordy;
        #1;
        en_m = !m_v[LA-1] || ordy;
        if (chk_on) begin
            check_eq("a_in_ready", 64'(a_in_ready), 64'(en_m));
            check_eq("a_out_valid", 64'(a_out_valid), 64'(m_v[LA-1]));
            if (m_v[LA-1]) begin
                ref_sqrt(longint'(m_d[LA-1]) << 8, r, m);
                check_eq("a_out_root", 64'(a_out_root), 64'(r));
                check_eq("a_out_rem", 64'(a_out_rem), 64'(m));
                check_eq("a_out_tag", 64'(a_out_tag), 64'(m_t[LA-1]));
            end
        end
        if (rst_v) begin
            for (int k = 0; k < LA; k++) m_v[k] = 0;
        end else if (en_m) begin
            for (int k = LA - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1];
                m_d[k] = m_d[k-1];
                m_t[k] = m_t[k-1];
            end
            m_v[0] = iv;
            m_d[0] = d;
            m_t[0] = t;
        end
    endtask

    initial begin
        longint r, m;
        logic [16:0] cdat [20];
        for (int k = 0; k < LA; k++) begin
            m_v[k] = 0;
            m_d[k] = '0;
            m_t[k] = '0;
        end

        // Reset, then check the idle state of all three instances.
        step_a(1, 0, 0, 0, 1);
        step_a(1, 0, 0, 0, 1);
        chk_on = 1;
        step_a(0, 0, 0, 0, 1);
        check_eq("a_rst_root", 64'(a_out_root), 64'd0);
        check_eq("a_rst_rem", 64'(a_out_rem), 64'd0);
        check_eq("a_rst_tag", 64'(a_out_tag), 64'd0);
        check_eq("b_rst_valid", 64'(b_out_valid), 64'd0);
        check_eq("c_rst_valid", 64'(c_out_valid), 64'd0);
        check_eq("c_rst_ready", 64'(c_in_ready), 64'd1);

        // Directed values including both range extremes.
        step_a(0, 1, 18'd16, 8'h5A, 1);
        step_a(0, 1, 18'd2, 8'h01, 1);
        step_a(0, 1, 18'd262143, 8'h02, 1);
        step_a(0, 1, 18'd0, 8'h03, 1);
        for (int i = 0; i < LA + 2; i++) step_a(0, 0, 0, 0, 1);

        // Continuous input with random backpressure.
        for (int i = 0; i < 200; i++)
            step_a(0, 1, 18'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        // Random bubbles and backpressure.
        for (int i = 0; i < 150; i++)
            step_a(0, 1'($urandom_range(0, 1)), 18'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)));
        for (int i = 0; i < LA + 20; i++) step_a(0, 0, 0, 0, 1);

        // Reset with five samples in flight; a fresh sample must still complete.
        for (int i = 0; i < 5; i++) step_a(0, 1, 18'($urandom), 8'(8'hA0 + i), 1);
        step_a(1, 1, 18'd99, 8'hEE, 1);
        step_a(0, 1, 18'd1000, 8'h77, 1);
        for (int i = 0; i < LA + 3; i++) step_a(0, 0, 0, 0, 1);
        a_in_valid = 0;

        // DUT B: back-to-back 1..100, one result per cycle at latency LB.
        for (int c = 0; c < 100 + LB; c++) begin
            @(negedge clk);
            b_in_valid = (c < 100);
            b_in_data = 18'(c + 1);
            b_in_tag = 8'(c);
            #1;
            if (c < LB) begin
                check_eq("b_fill_valid", 64'(b_out_valid), 64'd0);
            end else begin
                ref_sqrt(longint'(c - LB + 1) << 8, r, m);
                check_eq("b_out_valid", 64'(b_out_valid), 64'd1);
                check_eq("b_out_root", 64'(b_out_root), 64'(r));
                check_eq("b_out_rem", 64'(b_out_rem), 64'(m));
                check_eq("b_out_tag", 64'(b_out_tag), 64'((c - LB) & 255));
            end
        end
        b_in_valid = 0;

        // DUT C: odd input width, starting with the all-ones radicand.
        cdat[0] = 17'd131071;
        cdat[1] = 17'd0;
        cdat[2] = 17'd1;
        for (int i = 3; i < 20; i++) cdat[i] = 17'($urandom);
        for (int c = 0; c < 20 + LC; c++) begin
            @(negedge clk);
            c_in_valid = (c < 20);
            c_in_data = (c < 20) ? cdat[c] : 17'd0;
            c_in_tag = 8'(c);
            #1;
            if (c < LC) begin
                check_eq("c_fill_valid", 64'(c_out_valid), 64'd0);
            end else begin
                ref_sqrt(longint'(cdat[c-LC]), r, m);
                check_eq("c_out_valid", 64'(c_out_valid), 64'd1);
                check_eq("c_out_root", 64'(c_out_root), 64'(r));
                check_eq("c_out_rem", 64'(c_out_rem), 64'(m));
                check_eq("c_out_tag", 64'(c_out_tag), 64'(c - LC));
            end
        end
        c_in_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
